// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// State encoding, default width and divide-by-zero result.
package div_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All-ones quotient reported for x/0; sliced to the used width.
  localparam logic [63:0] DZ_QUOT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the switch board and the divider.
// master drives operands and start; slave returns results.
interface seq_divider_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             start;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output dividend,
    output divisor,
    output start,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  dividend,
    input  divisor,
    input  start,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Shifts the next dividend bit into R and tries to subtract.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nx,
  output logic [WIDTH-1:0] q_nx
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] trial;
  logic           unused_r_msb;

  // R never exceeds the divisor, so its top bit is always clear.
  assign unused_r_msb = r[WIDTH];

  // Keep the difference when it did not borrow, else restore.
  always_comb begin
    shl   = {r[WIDTH-1:0], q[WIDTH-1]};
    trial = shl - {1'b0, d};
    r_nx  = shl;
    q_nx  = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_nx    = trial;
      q_nx[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Results hold stable until the next accepted start.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] QDZ = DZ_QUOT[WIDTH-1:0];
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_nx;
  logic             start_q;
  logic             start_rise;
  logic             accept;
  logic             div_zero;
  logic             dz_pend;
  logic [WIDTH-1:0] dz_num;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dbz;

  assign start_rise = bus.start & ~start_q;
  assign accept     = start_rise & (state != ST_RUN) & ~dz_pend;
  assign div_zero   = (bus.divisor == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r    (r_q),
    .q    (q_q),
    .d    (d_q),
    .r_nx (r_nx),
    .q_nx (q_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state; x/0 spends one idle cycle before showing DONE.
  always_comb begin
    state_nx = state;
    if (dz_pend) begin
      state_nx = ST_DONE;
    end else if (accept) begin
      state_nx = div_zero ? ST_IDLE : ST_RUN;
    end else if (state == ST_RUN && cnt == '0) begin
      state_nx = ST_DONE;
    end
  end

  // Start edge detect; held-high button at reset release is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) start_q <= 1'b1;
    else        start_q <= bus.start;
  end

  // Operand latch, iteration registers and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_pend <= 1'b0;
      dz_num  <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
    end else begin
      dz_pend <= 1'b0;
      if (accept) begin
        dbz <= 1'b0;
        if (div_zero) begin
          dz_pend <= 1'b1;
          dz_num  <= bus.dividend;
        end else begin
          d_q <= bus.divisor;
          r_q <= '0;
          q_q <= bus.dividend;
          cnt <= CNT_LAST;
        end
      end
      if (dz_pend) begin
        quo <= QDZ;
        rem <= dz_num;
        dbz <= 1'b1;
      end
      if (state == ST_RUN) begin
        r_q <= r_nx;
        q_q <= q_nx;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          quo <= q_nx;
          rem <= r_nx[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign bus.busy        = (state == ST_RUN);
  assign bus.done        = (state == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider, 4-bit operands.
// Expected values are hand-computed or plain / and %.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [3:0] pq;
  logic [3:0] pr;
  int   bcnt;

  seq_divider_if #(.WIDTH(4)) bus ();

  seq_divider #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Start must have been low at the previous edge.
  // Returns 1ns after E0 with start already dropped.
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called 1ns after E0; checks busy window, hold, result at E0+4.
  task automatic finish_op(input string tag,
                           input logic [3:0] eq,
                           input logic [3:0] er);
    chk({tag, ".busy0"}, bus.busy, 1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({tag, ".busy"}, bus.busy, 1);
      chk({tag, ".done"}, bus.done, 0);
      chk({tag, ".holdq"}, bus.quotient, pq);
      chk({tag, ".holdr"}, bus.remainder, pr);
    end
    @(posedge clk); #1;
    chk({tag, ".fin_done"}, bus.done, 1);
    chk({tag, ".fin_busy"}, bus.busy, 0);
    chk({tag, ".q"}, bus.quotient, eq);
    chk({tag, ".r"}, bus.remainder, er);
    chk({tag, ".dbz"}, bus.div_by_zero, 0);
    pq = eq;
    pr = er;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    pq = 4'd0;
    pr = 4'd0;
    rst_n = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    bus.start    = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst.q", bus.quotient, 0);
    chk("rst.r", bus.remainder, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.dbz", bus.div_by_zero, 0);

    launch(4'd13, 4'd3);
    finish_op("d13_3", 4'd4, 4'd1);

    launch(4'd7, 4'd0);
    chk("dz.busy0", bus.busy, 0);
    chk("dz.done0", bus.done, 0);
    @(posedge clk); #1;
    chk("dz.q", bus.quotient, 15);
    chk("dz.r", bus.remainder, 7);
    chk("dz.dbz", bus.div_by_zero, 1);
    chk("dz.done", bus.done, 1);
    chk("dz.busy", bus.busy, 0);
    pq = 4'd15;
    pr = 4'd7;

    launch(4'd15, 4'd1);
    finish_op("d15_1", 4'd15, 4'd0);
    launch(4'd2, 4'd9);
    finish_op("d2_9", 4'd0, 4'd2);

    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    bus.start    = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.busy) bcnt++;
    end
    chk("hold.busycnt", bcnt, 4);
    chk("hold.q", bus.quotient, 4);
    chk("hold.r", bus.remainder, 1);
    chk("hold.done", bus.done, 1);
    pq = 4'd4;
    pr = 4'd1;
    bus.start = 1'b0;
    @(posedge clk); #1;

    launch(4'd6, 4'd3);
    @(posedge clk); #1;
    bus.dividend = 4'd15;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rerun.busy", bus.busy, 1);
    @(posedge clk); #1;
    chk("rerun.busy3", bus.busy, 1);
    chk("rerun.holdq", bus.quotient, 4);
    @(posedge clk); #1;
    chk("rerun.done", bus.done, 1);
    chk("rerun.q", bus.quotient, 2);
    chk("rerun.r", bus.remainder, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("rerun.idle", bus.busy, 0);
    chk("rerun.keepq", bus.quotient, 2);
    pq = 4'd2;
    pr = 4'd0;

    launch(4'd12, 4'd5);
    @(posedge clk);
    @(posedge clk); #2;
    bus.start = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst.q", bus.quotient, 0);
    chk("arst.r", bus.remainder, 0);
    chk("arst.busy", bus.busy, 0);
    chk("arst.done", bus.done, 0);
    chk("arst.dbz", bus.div_by_zero, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) bcnt++;
    end
    chk("arst.nolaunch", bcnt, 0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    pq = 4'd0;
    pr = 4'd0;
    launch(4'd12, 4'd5);
    finish_op("d12_5", 4'd2, 4'd2);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(4'(a), 4'(b));
        finish_op("sweep", 4'(a / b), 4'(a % b));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
